// File: rtl/tt_extractor.sv
// Truth-table extractor: drives all 128 minterms of a 7-input function and captures its output.
// Optional comparison against an expected table is enabled by defining TT_EXTRACTOR_COMPARE_EN.
module tt_extractor #(
    parameter int SETTLE = 0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         abort,
    output logic [6:0]   x,
    input  logic         fn_out,
    output logic         busy,
    output logic         done,
    output logic [127:0] tt,
    output logic         tt_valid
`ifdef TT_EXTRACTOR_COMPARE_EN
    ,
    input  logic [127:0] exp_tt,
    output logic         match,
    output logic [6:0]   first_mismatch
`endif
);

    typedef enum logic [1:0] {IDLE, WAIT, SAMPLE} state_t;

    localparam logic [3:0] SETTLE_LAST = 4'((SETTLE > 0) ? SETTLE - 1 : 0);
    localparam state_t     STEP_STATE  = (SETTLE > 0) ? WAIT : SAMPLE;

    state_t     state;
    logic [6:0] idx;
    logic [3:0] settle_cnt;

    assign x = idx;

`ifdef TT_EXTRACTOR_COMPARE_EN
    logic [127:0] exp_cap;
    logic [127:0] final_tt;
    logic [127:0] diff;
    logic [6:0]   first_idx;

    // The table as it will look after the final sampling edge, so the verdict lands with done.
    always_comb begin
        final_tt      = tt;
        final_tt[idx] = fn_out;
        diff          = final_tt ^ exp_cap;
        first_idx     = '0;
        for (int i = 127; i >= 0; i--) begin
            if (diff[i]) first_idx = 7'(i);
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tt_valid   <= 1'b0;
            tt         <= '0;
`ifdef TT_EXTRACTOR_COMPARE_EN
            exp_cap        <= '0;
            match          <= 1'b0;
            first_mismatch <= '0;
`endif
        end else if (state != IDLE && abort) begin
            // Partial table bits stay in place but are flagged invalid.
            state      <= IDLE;
            idx        <= '0;
            settle_cnt <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            tt_valid   <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start && !abort) begin
                        idx        <= '0;
                        settle_cnt <= '0;
                        tt_valid   <= 1'b0;
                        busy       <= 1'b1;
                        state      <= STEP_STATE;
`ifdef TT_EXTRACTOR_COMPARE_EN
                        exp_cap    <= exp_tt;
`endif
                    end
                end
                WAIT: begin
                    if (settle_cnt == SETTLE_LAST) begin
                        settle_cnt <= '0;
                        state      <= SAMPLE;
                    end else begin
                        settle_cnt <= settle_cnt + 4'd1;
                    end
                end
                SAMPLE: begin
                    tt[idx] <= fn_out;
                    if (idx == 7'd127) begin
                        idx      <= '0;
                        done     <= 1'b1;
                        tt_valid <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
`ifdef TT_EXTRACTOR_COMPARE_EN
                        match          <= (diff == '0);
                        first_mismatch <= first_idx;
`endif
                    end else begin
                        idx   <= idx + 7'd1;
                        state <= STEP_STATE;
                    end
                end
                default: begin
                    state <= IDLE;
                    idx   <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tt_extractor.sv
// Testbench for tt_extractor: a combinational-function instance (SETTLE=0) and a
// pipelined-function instance (SETTLE=2) checked against a whole-table reference model.
module tb_tt_extractor;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0] start_v = '0;
    logic [1:0] abort_v = '0;
    wire  [1:0] busy_v;
    wire  [1:0] done_v;
    wire  [1:0] valid_v;
    wire  [6:0] x_v [2];
    wire  [127:0] tt_v [2];
    wire  [1:0] fn_v;
    logic [1:0] fnPipe = '0;

    int fsel = 0;
    logic [127:0] rand_tbl = '0;
    logic [127:0] cmp_exp = '0;
    logic [127:0] prev_tt [2];
    logic [1:0] valid_exp = '0;
    int checks = 0;
    int errors = 0;

`ifdef TT_EXTRACTOR_COMPARE_EN
    wire [1:0] match_v;
    wire [6:0] fm_v [2];
`endif

    always #5 clk = ~clk;

    function automatic logic refFn(input int sel, input logic [6:0] v, input logic [127:0] tbl);
        case (sel)
            0: return 1'b0;
            1: return v[0];
            2: return v[6];
            3: return (32'(v[0]) + 32'(v[1]) + 32'(v[6])) >= 2;
            default: return tbl[v];
        endcase
    endfunction

    function automatic logic [127:0] modelTable(input int sel, input logic [127:0] tbl);
        logic [127:0] t;
        t = '0;
        for (int i = 0; i < 128; i++) t[i] = refFn(sel, 7'(i), tbl);
        return t;
    endfunction

    assign fn_v[0] = refFn(fsel, x_v[0], rand_tbl);
    // Two register stages so the SETTLE=2 instance only sees correct data if it waits long enough.
    always_ff @(posedge clk) fnPipe <= {fnPipe[0], refFn(fsel, x_v[1], rand_tbl)};
    assign fn_v[1] = fnPipe[1];

    tt_extractor #(.SETTLE(0)) dut0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .x(x_v[0]),
        .fn_out(fn_v[0]), .busy(busy_v[0]), .done(done_v[0]), .tt(tt_v[0]), .tt_valid(valid_v[0])
`ifdef TT_EXTRACTOR_COMPARE_EN
        , .exp_tt(cmp_exp), .match(match_v[0]), .first_mismatch(fm_v[0])
`endif
    );

    tt_extractor #(.SETTLE(2)) dut1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .x(x_v[1]),
        .fn_out(fn_v[1]), .busy(busy_v[1]), .done(done_v[1]), .tt(tt_v[1]), .tt_valid(valid_v[1])
`ifdef TT_EXTRACTOR_COMPARE_EN
        , .exp_tt(cmp_exp), .match(match_v[1]), .first_mismatch(fm_v[1])
`endif
    );

    task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic checkAllZero(input int g, input string tag);
        checkOutput({tag, "_busy"}, 128'(busy_v[g]), 128'(0));
        checkOutput({tag, "_done"}, 128'(done_v[g]), 128'(0));
        checkOutput({tag, "_valid"}, 128'(valid_v[g]), 128'(0));
        checkOutput({tag, "_x"}, 128'(x_v[g]), 128'(0));
        checkOutput({tag, "_tt"}, tt_v[g], 128'(0));
`ifdef TT_EXTRACTOR_COMPARE_EN
        checkOutput({tag, "_match"}, 128'(match_v[g]), 128'(0));
        checkOutput({tag, "_first_mismatch"}, 128'(fm_v[g]), 128'(0));
`endif
    endtask

    // One sweep on instance g; negative *_at values disable the corresponding disturbance.
    task automatic applyStimulus(input int g, input int sel, input int restart_at,
                                 input int abort_at, input int rst_at);
        int s, n, c, w, fm;
        bit x_ok, busy_ok, quiet;
        logic [127:0] exp, saved_cmp, merged;
        s = (g == 0) ? 0 : 2;
        n = 128 * (s + 1);
        fsel = sel;
        rand_tbl = {$urandom(), $urandom(), $urandom(), $urandom()};
        idle(4);
        exp = modelTable(sel, rand_tbl);
        saved_cmp = cmp_exp;
        start_v[g] = 1'b1;
        @(posedge clk); #1;
        checkOutput("valid_cleared_on_start", 128'(valid_v[g]), 128'(0));
        c = 0;
        x_ok = 1'b1;
        busy_ok = 1'b1;
        while (c <= n + 8) begin
            if (done_v[g] === 1'b1) break;
            if (abort_at >= 0 && c == abort_at + 1) break;
            if (rst_at >= 0 && c == rst_at + 1) break;
            if (x_v[g] !== 7'(c / (s + 1))) x_ok = 1'b0;
            if (busy_v[g] !== 1'b1) busy_ok = 1'b0;
            @(negedge clk);
            start_v[g] = (c == restart_at);
            abort_v[g] = (c == abort_at);
            rst = (c == rst_at);
            cmp_exp = {$urandom(), $urandom(), $urandom(), $urandom()};
            @(posedge clk); #1;
            c++;
        end
        checkOutput("x_follows_idx", 128'(x_ok), 128'(1));
        checkOutput("busy_during_sweep", 128'(busy_ok), 128'(1));
        if (rst_at >= 0) begin
            checkAllZero(g, "rst_mid_sweep");
            checkOutput("rst_other_tt", tt_v[1 - g], 128'(0));
            checkOutput("rst_other_valid", 128'(valid_v[1 - g]), 128'(0));
            prev_tt[0] = '0;
            prev_tt[1] = '0;
            valid_exp = '0;
            @(negedge clk);
            start_v = '0; abort_v = '0; rst = 1'b0;
        end else if (abort_at >= 0) begin
            w = abort_at / (s + 1);
            merged = prev_tt[g];
            for (int i = 0; i < w; i++) merged[i] = exp[i];
            checkOutput("abort_busy", 128'(busy_v[g]), 128'(0));
            checkOutput("abort_done", 128'(done_v[g]), 128'(0));
            checkOutput("abort_valid", 128'(valid_v[g]), 128'(0));
            checkOutput("abort_x", 128'(x_v[g]), 128'(0));
            checkOutput("abort_tt_retained", tt_v[g], merged);
            prev_tt[g] = merged;
            valid_exp[g] = 1'b0;
            @(negedge clk);
            start_v = '0; abort_v = '0; rst = 1'b0;
            quiet = 1'b1;
            repeat (n) begin
                @(posedge clk); #1;
                if (done_v[g] !== 1'b0 || busy_v[g] !== 1'b0) quiet = 1'b0;
            end
            checkOutput("abort_no_done", 128'(quiet), 128'(1));
        end else begin
            checkOutput("latency", 128'(c), 128'(n));
            checkOutput("done_pulse", 128'(done_v[g]), 128'(1));
            checkOutput("tt", tt_v[g], exp);
            checkOutput("tt_valid", 128'(valid_v[g]), 128'(1));
            checkOutput("busy_after", 128'(busy_v[g]), 128'(0));
`ifdef TT_EXTRACTOR_COMPARE_EN
            fm = 0;
            for (int i = 127; i >= 0; i--) if (exp[i] !== saved_cmp[i]) fm = i;
            checkOutput("match", 128'(match_v[g]), 128'(exp === saved_cmp));
            checkOutput("first_mismatch", 128'(fm_v[g]), 128'(fm));
`endif
            prev_tt[g] = exp;
            valid_exp[g] = 1'b1;
            @(negedge clk);
            start_v = '0; abort_v = '0; rst = 1'b0;
            @(posedge clk); #1;
            checkOutput("done_one_cycle", 128'(done_v[g]), 128'(0));
            checkOutput("idle_busy", 128'(busy_v[g]), 128'(0));
            checkOutput("idle_x", 128'(x_v[g]), 128'(0));
            @(negedge clk);
        end
    endtask

    initial begin
        prev_tt[0] = '0;
        prev_tt[1] = '0;
        repeat (3) @(posedge clk);
        #1;
        checkAllZero(0, "reset0");
        checkAllZero(1, "reset1");
        @(negedge clk);
        rst = 1'b0;

        $display("[TB] constant-zero and single-variable functions");
        applyStimulus(0, 0, -1, -1, -1);
        cmp_exp = {4{32'hAAAAAAAA}} ^ (128'(1) << 5);
        applyStimulus(0, 1, -1, -1, -1);
        checkOutput("x0_pattern", tt_v[0], {4{32'hAAAAAAAA}});
`ifdef TT_EXTRACTOR_COMPARE_EN
        checkOutput("flipped_match", 128'(match_v[0]), 128'(0));
        checkOutput("flipped_first_mismatch", 128'(fm_v[0]), 128'(5));
`endif
        cmp_exp = {4{32'hAAAAAAAA}};
        applyStimulus(0, 1, -1, -1, -1);
`ifdef TT_EXTRACTOR_COMPARE_EN
        checkOutput("exact_match", 128'(match_v[0]), 128'(1));
        checkOutput("exact_first_mismatch", 128'(fm_v[0]), 128'(0));
`endif
        applyStimulus(0, 2, -1, -1, -1);
        checkOutput("x6_pattern", tt_v[0], {{2{32'hFFFFFFFF}}, 64'h0});

        $display("[TB] majority function with settle wait");
        applyStimulus(1, 3, -1, -1, -1);

        $display("[TB] start while busy, start at done, abort/start in idle");
        applyStimulus(0, 4, 40, -1, -1);
        applyStimulus(0, 4, 127, -1, -1);
        applyStimulus(1, 4, 383, -1, -1);
        abort_v = 2'b11;
        start_v[0] = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_abort_start_busy", 128'(busy_v[0]), 128'(0));
        checkOutput("idle_abort_valid0", 128'(valid_v[0]), 128'(valid_exp[0]));
        checkOutput("idle_abort_valid1", 128'(valid_v[1]), 128'(valid_exp[1]));
        checkOutput("idle_abort_tt1", tt_v[1], prev_tt[1]);
        @(negedge clk);
        abort_v = '0;
        start_v = '0;

        $display("[TB] abort mid-sweep");
        applyStimulus(0, 4, -1, 50, -1);
        applyStimulus(1, 4, -1, 100, -1);

        $display("[TB] reset mid-sweep then recovery");
        applyStimulus(0, 4, -1, -1, 70);
        applyStimulus(0, 4, -1, -1, -1);
        applyStimulus(1, 4, -1, -1, -1);

        for (int k = 0; k < 4; k++) begin
            cmp_exp = {$urandom(), $urandom(), $urandom(), $urandom()};
            applyStimulus(k % 2, 4, -1, -1, -1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tt_extractor.md
TT_EXTRACTOR -- requirements
Module: tt_extractor

Interface
REQ-001 Parameter SETTLE, default 0; extra wait cycles per minterm before sampling, legal range 0..15.
REQ-002 clk  input  1  sole clock, rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request a full 128-minterm sweep; accepted only in IDLE.
REQ-005 abort  input  1  terminate a running sweep.
REQ-006 x  output  7  minterm driven to the 7-input function under test; x[0] is x0 (LSB), x[6] is x6.
REQ-007 fn_out  input  1  function output for the current x; combinational from x, or registered if SETTLE>0.
REQ-008 busy  output  1  high while a sweep is in progress.
REQ-009 done  output  1  one-cycle pulse when a sweep completes.
REQ-010 tt  output  128  captured truth table; tt[i] = fn_out at x==i, so tt[127] is the MSB of the hex name.
REQ-011 tt_valid  output  1  tt holds a complete, unaborted sweep.

Function
REQ-012 States: IDLE, WAIT, SAMPLE. Internal 7-bit minterm counter idx and 4-bit settle counter.
REQ-013 IDLE with start=1 at an edge: idx<=0, tt_valid<=0, busy<=1, next state WAIT if SETTLE>0, else SAMPLE.
REQ-014 x shall equal idx in every cycle; x holds 0 in IDLE.
REQ-015 WAIT lasts exactly SETTLE cycles, then goes to SAMPLE.
REQ-016 SAMPLE lasts one cycle: at its closing edge, tt[idx]<=fn_out.
REQ-017 SAMPLE with idx<127: idx<=idx+1 and the FSM re-enters WAIT, or stays in SAMPLE if SETTLE=0.
REQ-018 SAMPLE with idx==127: at the sampling edge, done<=1 for one cycle, tt_valid<=1, busy<=0, state<=IDLE, idx<=0; idx shall not wrap into a second sweep.
REQ-019 Latency: a sweep occupies exactly 128*(SETTLE+1) cycles from the start-accept edge to the done edge.
REQ-020 start while busy is ignored, with no restart and no effect on idx.
REQ-021 start and done in the same cycle: start is not accepted, because the FSM is not yet in IDLE.
REQ-022 abort while busy: at the next edge the FSM returns to IDLE with busy=0, done=0, tt_valid=0 and idx=0; tt bits already written are retained but invalid.
REQ-023 abort in IDLE has no effect; abort and start together in IDLE means start is ignored.
REQ-024 tt bits are written only in SAMPLE; otherwise tt holds its value between sweeps.

Reset
REQ-025 While rst=1 at an edge, the block shall be forced to: IDLE, idx=0, x=0, busy=0, done=0, tt_valid=0, tt=0.
REQ-026 rst mid-sweep aborts immediately; rst overrides start and abort.

Configuration
REQ-027 Macro TT_EXTRACTOR_COMPARE_EN, when defined, adds the following ports:
- exp_tt  input  128  expected truth table;
- match  output  1;
- first_mismatch  output  7.
REQ-028 With the macro defined: exp_tt is captured at the start-accept edge. At the done edge:
- match<=1 if tt equals the captured exp_tt, else 0;
- first_mismatch<=lowest index i where tt[i]!=exp_tt[i], or 0 if all bits match.
Both outputs are reset to 0 and held until the next done.
REQ-029 With the macro undefined, these ports and their logic are absent; all other behaviour is identical.

Verification
REQ-030 SETTLE=0, fn_out tied 0, start pulse -> done exactly 128 cycles after the accept edge; tt=0, tt_valid=1.
REQ-031 fn_out=x[0] -> tt=128'hAAAAAAAA_AAAAAAAA_AAAAAAAA_AAAAAAAA; fn_out=x[6] -> tt=128'hFFFFFFFF_FFFFFFFF_00000000_00000000.
REQ-032 fn_out=maj(x0,x1,x6), SETTLE=2 -> done 384 cycles after accept; tt bit i = majority of bits 0, 1 and 6 of i; busy is never high outside the sweep.
REQ-033 start re-pulsed at cycle 40 of a sweep -> ignored, done at cycle 128; abort at cycle 50 -> busy=0 next cycle, no done, tt_valid=0.
REQ-034 rst asserted at cycle 70 of a sweep -> all outputs 0 next cycle; a new start then yields a complete correct sweep.
REQ-035 COMPARE_EN, fn_out=x[0], exp_tt = the x[0] pattern with bit 5 flipped -> match=0, first_mismatch=5; with the exact pattern -> match=1, first_mismatch=0.
